// File: rtl/mnist_pkg.sv
// Shared state encoding, size defaults and score type for the MNIST inference sequencer.
// Latency: none (types and constants only).
// Backpressure: none.
package mnist_pkg;

   localparam int IMG_PIXELS_DEF   = 784;
   localparam int NUM_CLASSES_DEF  = 10;
   localparam int RESULT_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      WAIT_LOAD = 2'd0,
      IDLE      = 2'd1,
      FEED      = 2'd2,
      COLLECT   = 2'd3
   } infer_state_e;

   typedef logic signed [RESULT_WIDTH_DEF-1:0] score_t;

endpackage

// File: rtl/mnist_argmax.sv
// Streaming argmax over signed scores; strict greater-than so the lowest index wins ties.
// Latency: best_* registered one cycle after the beat; nxt_* shows the value being loaded.
// Backpressure: none; every beat with vld_i high is consumed.
module mnist_argmax
   import mnist_pkg::*;
#(
   parameter int IDX_W   = 4,
   parameter int SCORE_W = RESULT_WIDTH_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clr_i,
   input  logic                      vld_i,
   input  logic [IDX_W-1:0]          idx_i,
   input  logic signed [SCORE_W-1:0] score_i,
   output logic [IDX_W-1:0]          best_idx_o,
   output logic signed [SCORE_W-1:0] best_score_o,
   output logic [IDX_W-1:0]          nxt_idx_o,
   output logic signed [SCORE_W-1:0] nxt_score_o
);

   logic                      first_q, first_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic signed [SCORE_W-1:0] score_q, score_d;

   // Next best: clear restarts the search; the first beat always loads, later ones only if strictly larger
   always_comb begin
      first_d = first_q;
      idx_d   = idx_q;
      score_d = score_q;
      if (clr_i) begin
         first_d = 1'b1;
         idx_d   = '0;
         score_d = '0;
      end else if (vld_i) begin
         first_d = 1'b0;
         if (first_q || (score_i > score_q)) begin
            idx_d   = idx_i;
            score_d = score_i;
         end
      end
   end

   // Best-so-far registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         first_q <= 1'b1;
         idx_q   <= '0;
         score_q <= '0;
      end else begin
         first_q <= first_d;
         idx_q   <= idx_d;
         score_q <= score_d;
      end
   end

   assign best_idx_o   = idx_q;
   assign best_score_o = score_q;
   assign nxt_idx_o    = idx_d;
   assign nxt_score_o  = score_d;

endmodule

// File: rtl/mnist_infer_ctrl.sv
// Inference sequencer: waits for weights, streams one frame into the core, argmaxes the class scores.
// Latency: pixel strobes start 2 cycles after start; done 1 cycle after the last score beat.
// Backpressure: none; start is ignored while busy, beats outside FEED/COLLECT are dropped. Option: INFER_PERF_CNT_EN.
module mnist_infer_ctrl
   import mnist_pkg::*;
#(
   parameter int IMG_PIXELS     = IMG_PIXELS_DEF,
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_CLASSES    = NUM_CLASSES_DEF,
   parameter int RESULT_WIDTH   = RESULT_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           weights_ready_i,
   input  logic                           start_i,
   output logic [$clog2(IMG_PIXELS)-1:0]  pix_rd_addr_o,
   input  logic [DATA_WIDTH-1:0]          pix_rd_data_i,
   output logic                           core_valid_in_o,
   output logic [DATA_WIDTH-1:0]          core_pixel_o,
   input  logic signed [RESULT_WIDTH-1:0] core_result_i,
   input  logic                           core_result_valid_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           error_o,
   output logic [3:0]                     pred_class_o,
   output logic signed [RESULT_WIDTH-1:0] pred_score_o
`ifdef INFER_PERF_CNT_EN
   ,
   output logic [31:0]                    perf_cycles_o,
   output logic [15:0]                    frame_count_o
`endif
);

   localparam int AW = $clog2(IMG_PIXELS);
   localparam int CW = $clog2(NUM_CLASSES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_PIXELS - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(NUM_CLASSES);
   localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

   infer_state_e              state_q, state_d;
   logic [AW-1:0]             addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     pix_q, pix_d;
   logic                      vld_q, vld_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [WW-1:0]             wd_q, wd_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic [3:0]                cls_q, cls_d;
   logic signed [RESULT_WIDTH-1:0] score_q, score_d;

   logic                      busy;
   logic                      accept;
   logic                      beat;
   logic                      frame_ok;
   logic                      frame_to;
   logic [3:0]                best_idx, nxt_idx;
   logic signed [RESULT_WIDTH-1:0] best_score, nxt_score;

   assign busy   = (state_q == FEED) || (state_q == COLLECT);
   assign accept = (state_q == IDLE) && weights_ready_i && start_i;
   assign beat   = busy && core_result_valid_i && (cnt_q != CNT_FULL);

   mnist_argmax #(
      .IDX_W   (4),
      .SCORE_W (RESULT_WIDTH)
   ) u_argmax (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clr_i        (accept),
      .vld_i        (beat),
      .idx_i        (4'(cnt_q)),
      .score_i      (core_result_i),
      .best_idx_o   (best_idx),
      .best_score_o (best_score),
      .nxt_idx_o    (nxt_idx),
      .nxt_score_o  (nxt_score)
   );

   // Next state: sequencing, pixel feed, result counting, watchdog and frame close-out
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      pix_d    = pix_q;
      vld_d    = 1'b0;
      cnt_d    = cnt_q;
      wd_d     = wd_q;
      done_d   = 1'b0;
      err_d    = err_q;
      cls_d    = cls_q;
      score_d  = score_q;
      frame_ok = 1'b0;
      frame_to = 1'b0;

      if (beat) cnt_d = cnt_q + CW'(1);
      if (busy) wd_d = wd_q + WW'(1);

      case (state_q)
         WAIT_LOAD: begin
            if (weights_ready_i) state_d = IDLE;
         end
         IDLE: begin
            if (!weights_ready_i) begin
               state_d = WAIT_LOAD;
            end else if (start_i) begin
               state_d = FEED;
               addr_d  = '0;
               cnt_d   = '0;
               wd_d    = '0;
               err_d   = 1'b0;
            end
         end
         FEED: begin
            // buffer data for addr_q is captured here, so strobes trail addresses by one cycle
            vld_d = 1'b1;
            pix_d = pix_rd_data_i;
            if (addr_q == LAST_ADDR) state_d = COLLECT;
            else                     addr_d  = addr_q + AW'(1);
         end
         default: begin
         end
      endcase

      // Completion takes precedence over a watchdog expiry on the same edge
      if ((state_q == COLLECT) && (cnt_d == CNT_FULL)) frame_ok = 1'b1;
      else if (busy && (wd_q == WD_LAST))               frame_to = 1'b1;

      if (frame_ok || frame_to) begin
         state_d = IDLE;
         done_d  = 1'b1;
         if (frame_to) err_d = 1'b1;
         // a beat landing on the closing edge must be part of the reported result
         cls_d   = beat ? nxt_idx   : best_idx;
         score_d = beat ? nxt_score : best_score;
      end
   end

   // Controller state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= WAIT_LOAD;
         addr_q  <= '0;
         pix_q   <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
         wd_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cls_q   <= '0;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pix_q   <= pix_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cls_q   <= cls_d;
         score_q <= score_d;
      end
   end

   assign pix_rd_addr_o   = addr_q;
   assign core_valid_in_o = vld_q;
   assign core_pixel_o    = pix_q;
   assign busy_o          = busy;
   assign done_o          = done_q;
   assign error_o         = err_q;
   assign pred_class_o    = cls_q;
   assign pred_score_o    = score_q;

`ifdef INFER_PERF_CNT_EN
   logic [31:0] run_q, run_d;
   logic [31:0] perf_q, perf_d;
   logic [15:0] fcnt_q, fcnt_d;

   // Perf next state: run counts edges from the accepted start, latched on done; clean frames counted
   always_comb begin
      run_d  = run_q;
      perf_d = perf_q;
      fcnt_d = fcnt_q;
      if (accept)    run_d = 32'd1;
      else if (busy) run_d = run_q + 32'd1;
      if (frame_ok || frame_to) perf_d = run_q + 32'd1;
      if (frame_ok)             fcnt_d = fcnt_q + 16'd1;
   end

   // Perf counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_q  <= '0;
         perf_q <= '0;
         fcnt_q <= '0;
      end else begin
         run_q  <= run_d;
         perf_q <= perf_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign perf_cycles_o = perf_q;
   assign frame_count_o = fcnt_q;
`endif

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// Self-checking bench for mnist_infer_ctrl: random score streams against a reference argmax model.
// Latency: checks strobe window, done timing and watchdog expiry against edge counts from start.
// Backpressure: n/a; the bench plays image buffer (async read) and network core.
`timescale 1ns/1ps
module tb_mnist_infer_ctrl;
   import mnist_pkg::*;

   localparam int NPIX = 784;
   localparam int TO   = 2000;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              weights_ready_i;
   logic              start_i;
   logic [9:0]        pix_rd_addr_o;
   logic [7:0]        pix_rd_data_i;
   logic              core_valid_in_o;
   logic [7:0]        core_pixel_o;
   logic signed [31:0] core_result_i;
   logic              core_result_valid_i;
   logic              busy_o;
   logic              done_o;
   logic              error_o;
   logic [3:0]        pred_class_o;
   logic signed [31:0] pred_score_o;
`ifdef INFER_PERF_CNT_EN
   logic [31:0]       perf_cycles_o;
   logic [15:0]       frame_count_o;
`endif

   logic [7:0] mem [NPIX];
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         strb_cyc[$];
   logic [7:0] strb_dat[$];
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         busy_seen = 0;
   int         exp_frames = 0;
   score_t     sc[10];

   always #5 clk_i = ~clk_i;

   assign pix_rd_data_i = mem[pix_rd_addr_o];

   mnist_infer_ctrl #(
      .IMG_PIXELS     (NPIX),
      .DATA_WIDTH     (8),
      .NUM_CLASSES    (10),
      .RESULT_WIDTH   (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .weights_ready_i     (weights_ready_i),
      .start_i             (start_i),
      .pix_rd_addr_o       (pix_rd_addr_o),
      .pix_rd_data_i       (pix_rd_data_i),
      .core_valid_in_o     (core_valid_in_o),
      .core_pixel_o        (core_pixel_o),
      .core_result_i       (core_result_i),
      .core_result_valid_i (core_result_valid_i),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .error_o             (error_o),
      .pred_class_o        (pred_class_o),
      .pred_score_o        (pred_score_o)
`ifdef INFER_PERF_CNT_EN
      ,
      .perf_cycles_o       (perf_cycles_o),
      .frame_count_o       (frame_count_o)
`endif
   );

   // Edge counter: value after a posedge is that edge's index
   always @(posedge clk_i) cyc <= cyc + 1;

   // Passive monitor on the falling edge
   always @(negedge clk_i) begin
      if (core_valid_in_o === 1'b1) begin
         strb_cyc.push_back(cyc);
         strb_dat.push_back(core_pixel_o);
      end
      if (done_o === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (busy_o === 1'b1) busy_seen = busy_seen + 1;
   end

   task automatic check_eq(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: find the maximum first, then the lowest index holding it
   function automatic void ref_argmax(input int n, output int cls, output int scr);
      int mx;
      cls = 0;
      scr = 0;
      if (n == 0) return;
      mx = int'(sc[0]);
      for (int i = 1; i < n; i++) if (int'(sc[i]) > mx) mx = int'(sc[i]);
      for (int i = n - 1; i >= 0; i--) if (int'(sc[i]) == mx) cls = i;
      scr = mx;
   endfunction

   task automatic fill_random(input bit ties);
      for (int i = 0; i < 10; i++) begin
         if (ties) sc[i] = score_t'(int'($urandom_range(0, 8)) - 4);
         else      sc[i] = score_t'($urandom);
      end
   endtask

   task automatic run_frame(input int nb, input bit mid_start, input bit exp_to);
      int e0, r_edge, t, dn0, dly, exp_cls, exp_scr, exp_done, bad, first, last;
      t = 0;
      while (busy_o !== 1'b0 && t < 5000) begin @(negedge clk_i); t++; end
      @(negedge clk_i);
      start_i = 1'b1;
      @(posedge clk_i); #1;
      e0  = cyc;
      dn0 = done_cnt;
      strb_cyc.delete();
      strb_dat.delete();
      check_eq("busy_after_start", busy_o, 1);
      check_eq("addr_after_start", pix_rd_addr_o, 0);
      check_eq("error_cleared_by_start", error_o, 0);
      @(negedge clk_i);
      start_i = 1'b0;
      dly = mid_start ? 300 : $urandom_range(0, 850);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk_i);
         start_i = (mid_start && i == 40);
      end
      start_i = 1'b0;
      r_edge = e0;
      for (int k = 0; k < nb; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
         core_result_valid_i = 1'b1;
         core_result_i       = sc[k];
         @(posedge clk_i); #1;
         r_edge = cyc;
         @(negedge clk_i);
         core_result_valid_i = 1'b0;
      end
      t = 0;
      while (done_cnt == dn0 && t < 3000) begin @(negedge clk_i); t++; end
      check_eq("done_within_bound", done_cnt != dn0, 1);
      repeat (3) @(negedge clk_i);
      ref_argmax(nb, exp_cls, exp_scr);
      if (exp_to)                    exp_done = e0 + TO;
      else if (r_edge > e0 + NPIX + 1) exp_done = r_edge;
      else                           exp_done = e0 + NPIX + 1;
      check_eq("done_pulse_count", done_cnt - dn0, 1);
      check_eq("done_edge", done_cyc, exp_done);
      check_eq("pred_class", pred_class_o, exp_cls);
      check_eq("pred_score", pred_score_o, exp_scr);
      check_eq("error_flag", error_o, exp_to);
      check_eq("busy_after_done", busy_o, 0);
      check_eq("strobe_count", strb_cyc.size(), NPIX);
      first = (strb_cyc.size() > 0) ? strb_cyc[0] : -1;
      last  = (strb_cyc.size() > 0) ? strb_cyc[strb_cyc.size() - 1] : -1;
      check_eq("first_strobe_edge", first, e0 + 1);
      check_eq("strobe_span", last - first + 1, strb_cyc.size());
      bad = 0;
      foreach (strb_dat[i]) if (i < NPIX && strb_dat[i] !== mem[i]) bad++;
      check_eq("pixel_data_errors", bad, 0);
`ifdef INFER_PERF_CNT_EN
      if (!exp_to) exp_frames++;
      check_eq("perf_cycles", perf_cycles_o, done_cyc - e0 + 1);
      check_eq("frame_count", frame_count_o, exp_frames);
`endif
   endtask

   initial begin
      #600000;
      n_errors++;
      $display("FAIL global_timeout: got no finish expected finish before 60000 cycles");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      int t, dn0, cls0;
      for (int i = 0; i < NPIX; i++) mem[i] = 8'((i * 3) & 8'hFF);
      rst_i = 1'b1;
      weights_ready_i = 1'b0;
      start_i = 1'b0;
      core_result_valid_i = 1'b0;
      core_result_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_valid", core_valid_in_o, 0);
      check_eq("rst_done", done_o, 0);
      check_eq("rst_error", error_o, 0);
      check_eq("rst_addr", pix_rd_addr_o, 0);
      check_eq("rst_pixel", core_pixel_o, 0);
      check_eq("rst_pred_class", pred_class_o, 0);
      check_eq("rst_pred_score", pred_score_o, 0);
`ifdef INFER_PERF_CNT_EN
      check_eq("rst_perf", perf_cycles_o, 0);
      check_eq("rst_frames", frame_count_o, 0);
`endif
      @(negedge clk_i);
      rst_i = 1'b0;

      // Weights not loaded: start must be ignored
      @(posedge clk_i); #1;
      busy_seen = 0;
      strb_cyc.delete();
      strb_dat.delete();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         start_i = (i % 7 == 3);
      end
      start_i = 1'b0;
      @(negedge clk_i);
      check_eq("wait_load_busy", busy_seen, 0);
      check_eq("wait_load_strobes", strb_cyc.size(), 0);

      weights_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);

      sc[0] = -5; sc[1] = 12; sc[2] = 3;  sc[3] = 12; sc[4] = 0;
      sc[5] = -1; sc[6] = 7;  sc[7] = 2;  sc[8] = 11; sc[9] = 4;
      run_frame(10, 1'b0, 1'b0);

      // Beats while idle must not disturb anything
      dn0  = done_cnt;
      cls0 = int'(pred_class_o);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         core_result_valid_i = 1'b1;
         core_result_i = 32'sd1000;
      end
      @(negedge clk_i);
      core_result_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_eq("idle_beats_no_done", done_cnt - dn0, 0);
      check_eq("idle_beats_pred_hold", pred_class_o, cls0);

      for (int i = 0; i < 9; i++) sc[i] = score_t'(-4 - int'($urandom_range(0, 1000)));
      sc[9] = -3;
      run_frame(10, 1'b0, 1'b0);

      fill_random(1'b1);
      run_frame(10, 1'b1, 1'b0);
      fill_random(1'b0);
      run_frame(10, 1'b0, 1'b0);

      // Watchdog: only six beats arrive
      fill_random(1'b0);
      run_frame(6, 1'b0, 1'b1);
      repeat (20) @(negedge clk_i);
      check_eq("error_sticky", error_o, 1);
      fill_random(1'b1);
      run_frame(10, 1'b0, 1'b0);

      // Reset in the middle of the pixel burst
      @(posedge clk_i); #1;
      strb_cyc.delete();
      strb_dat.delete();
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      t = 0;
      while (strb_cyc.size() < 300 && t < 2000) begin @(negedge clk_i); t++; end
      check_eq("reached_strobe_300", strb_cyc.size(), 300);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check_eq("midrst_valid", core_valid_in_o, 0);
      check_eq("midrst_busy", busy_o, 0);
      check_eq("midrst_addr", pix_rd_addr_o, 0);
      check_eq("midrst_pixel", core_pixel_o, 0);
      check_eq("midrst_pred_class", pred_class_o, 0);
      check_eq("midrst_pred_score", pred_score_o, 0);
      check_eq("midrst_error", error_o, 0);
      check_eq("midrst_state", dut.state_q, WAIT_LOAD);
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_frames = 0;

      // Two frames back to back after reset
      fill_random(1'b1);
      run_frame(10, 1'b0, 1'b0);
      fill_random(1'b0);
      run_frame(10, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
